// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the response beat
// record used by the read (and write) response paths.
package axi4_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Widest data bus any AXI4-Lite slave here supports.
   localparam int AXI4_LITE_MAX_DATA_W = 64;

   typedef struct packed {
      logic [AXI4_LITE_MAX_DATA_W-1:0] data;
      logic [1:0]                      resp;
   } axi4_lite_resp_t;

   // Response code for a completed access.
   function automatic logic [1:0] resp_code(input logic is_error);
      return is_error ? RESP_SLVERR : RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi4_lite_resp_fifo.sv
// Small synchronous FIFO for AXI response beats. The head is visible
// combinationally, so a pushed entry appears at the output one cycle later.
// Push and pop in the same cycle are both honoured, even when full.
module axi4_lite_resp_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_pop  = i_pop & (r_count != '0);
   assign w_do_push = i_push & ((r_count != FULL_CNT) | w_do_pop);

   // Storage array: written at the tail, no reset needed.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == FULL_CNT);
   assign o_count = r_count;

endmodule

// File: rtl/axi4_lite_read_slave.sv
// AXI4-Lite read-channel slave in front of a register backend.
// Accepted reads strobe the backend in the AR cycle, capture its data one
// cycle later and queue {data, resp} in a response FIFO driving the R channel.
// ARREADY comes from a credit counter (FIFO occupancy + in-flight read).
// Optional build macro: AXI4_READ_ALIGN_CHECK_EN -- misaligned addresses
// answer SLVERR without touching the backend.
module axi4_lite_read_slave
   import axi4_lite_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 8,
   parameter int NUM_REGS      = 16,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                        axi_clk,
   input  logic                        reset,
   input  logic [ADDRESS_WIDTH-1:0]    read_addr,
   input  logic                        read_addr_valid,
   output logic                        read_addr_ready,
   output logic [DATA_WIDTH-1:0]       read_data,
   output logic [1:0]                  read_resp,
   output logic                        read_data_valid,
   input  logic                        read_data_ready,
   output logic                        reg_read_enable,
   output logic [$clog2(NUM_REGS)-1:0] reg_read_index,
   input  logic [DATA_WIDTH-1:0]       reg_read_data
);

   localparam int BYTE_BITS = $clog2(DATA_WIDTH/8);
   localparam int WORD_W    = ADDRESS_WIDTH - BYTE_BITS;
   localparam int IDX_W     = $clog2(NUM_REGS);
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam int FIFO_W    = DATA_WIDTH + 2;
   localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
   localparam int unsigned      NUM_REGS_U = NUM_REGS;

   logic [WORD_W-1:0] w_word_idx;
   logic              w_in_range;
   logic              w_misaligned;
   logic              w_accept;
   logic              w_accept_ok;
   logic              w_pop;
   logic [CNT_W-1:0]  w_credits_next;
   logic [CNT_W-1:0]  r_credits;
   logic              r_arready;
   logic              r_inflight_valid;
   logic              r_inflight_err;
   axi4_lite_resp_t   w_push_resp;
   logic [FIFO_W-1:0] w_push_word;
   logic [FIFO_W-1:0] w_fifo_head;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic [CNT_W-1:0]  w_fifo_count;
   logic              w_unused_push_hi;
   logic              w_unused_fifo_status;

   // Address decode: word index and range check.
   assign w_word_idx = read_addr[ADDRESS_WIDTH-1:BYTE_BITS];
   assign w_in_range = (32'(w_word_idx) < NUM_REGS_U);

`ifdef AXI4_READ_ALIGN_CHECK_EN
   assign w_misaligned = |read_addr[BYTE_BITS-1:0];
`else
   // Byte offset is ignored: a misaligned address reads its containing word.
   logic w_unused_offset;
   assign w_unused_offset = ^read_addr[BYTE_BITS-1:0];
   assign w_misaligned    = 1'b0;
`endif

   assign w_accept        = read_addr_valid & r_arready;
   assign w_accept_ok     = w_accept & w_in_range & ~w_misaligned;
   assign reg_read_enable = w_accept_ok;
   assign reg_read_index  = w_accept_ok ? w_word_idx[IDX_W-1:0] : '0;
   assign read_addr_ready = r_arready;
   assign w_pop           = ~w_fifo_empty & read_data_ready;

   // Credit update: +1 per accepted address, -1 per R handshake.
   always_comb begin
      w_credits_next = r_credits;
      if (w_accept && !w_pop) begin
         w_credits_next = r_credits + CNT_W'(1);
      end else if (!w_accept && w_pop) begin
         w_credits_next = r_credits - CNT_W'(1);
      end
   end

   // Credit counter and registered ARREADY (never combinational on inputs).
   always_ff @(posedge axi_clk or posedge reset) begin
      if (reset) begin
         r_credits <= '0;
         r_arready <= 1'b0;
      end else begin
         r_credits <= w_credits_next;
         r_arready <= (w_credits_next < DEPTH_CNT);
      end
   end

   // In-flight slot: remembers an accepted read until backend data is valid.
   always_ff @(posedge axi_clk or posedge reset) begin
      if (reset) begin
         r_inflight_valid <= 1'b0;
         r_inflight_err   <= 1'b0;
      end else begin
         r_inflight_valid <= w_accept;
         r_inflight_err   <= ~(w_in_range & ~w_misaligned);
      end
   end

   // Response beat for the in-flight read: backend data or SLVERR with zero data.
   always_comb begin
      w_push_resp.resp = resp_code(r_inflight_err);
      w_push_resp.data = '0;
      if (!r_inflight_err) begin
         w_push_resp.data = AXI4_LITE_MAX_DATA_W'(reg_read_data);
      end
   end

   assign w_push_word      = {w_push_resp.data[DATA_WIDTH-1:0], w_push_resp.resp};
   assign w_unused_push_hi = ^w_push_resp.data;

   axi4_lite_resp_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_resp_fifo (
      .clk         (axi_clk),
      .rst         (reset),
      .i_push      (r_inflight_valid),
      .i_push_data (w_push_word),
      .i_pop       (w_pop),
      .o_head      (w_fifo_head),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty),
      .o_count     (w_fifo_count)
   );

   // Credits already bound occupancy, so full/count are not consulted here.
   assign w_unused_fifo_status = w_fifo_full ^ (^w_fifo_count);

   // R channel is the FIFO head, forced to zero while empty.
   assign read_data_valid = ~w_fifo_empty;
   assign read_data       = w_fifo_empty ? '0 : w_fifo_head[FIFO_W-1:2];
   assign read_resp       = w_fifo_empty ? RESP_OKAY : w_fifo_head[1:0];

endmodule

// File: tb/tb_axi4_lite_read_slave.sv
// Testbench for axi4_lite_read_slave (32-bit data, 8-bit address, 16 regs,
// FIFO depth 4). Expected R beats are queued at each AR handshake and
// compared when the DUT returns them.
module tb_axi4_lite_read_slave;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int NR = 16;
   localparam int FD = 4;
`ifdef AXI4_READ_ALIGN_CHECK_EN
   localparam bit ALIGN_CHK = 1'b1;
`else
   localparam bit ALIGN_CHK = 1'b0;
`endif

   logic          axi_clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] read_addr = '0;
   logic          read_addr_valid = 1'b0;
   logic          read_addr_ready;
   logic [DW-1:0] read_data;
   logic [1:0]    read_resp;
   logic          read_data_valid;
   logic          read_data_ready = 1'b0;
   logic          reg_read_enable;
   logic [3:0]    reg_read_index;
   logic [DW-1:0] reg_read_data = '0;

   int n_cmp = 0;
   int n_err = 0;
   logic [DW+1:0] sb_q [$];

   // snapshot of the last sampled cycle
   logic          s_ar_hs, s_r_hs, s_ready, s_rvalid, s_en, s_arvalid;
   logic [DW-1:0] s_rdata;
   logic [1:0]    s_rresp;
   logic [3:0]    s_idx;
   logic          p_stall = 1'b0;
   logic [DW-1:0] p_data;
   logic [1:0]    p_resp;

   always #5 axi_clk = ~axi_clk;

   axi4_lite_read_slave #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW),
      .NUM_REGS      (NR),
      .FIFO_DEPTH    (FD)
   ) dut (
      .axi_clk         (axi_clk),
      .reset           (reset),
      .read_addr       (read_addr),
      .read_addr_valid (read_addr_valid),
      .read_addr_ready (read_addr_ready),
      .read_data       (read_data),
      .read_resp       (read_resp),
      .read_data_valid (read_data_valid),
      .read_data_ready (read_data_ready),
      .reg_read_enable (reg_read_enable),
      .reg_read_index  (reg_read_index),
      .reg_read_data   (reg_read_data)
   );

   function automatic logic [DW-1:0] bmem(input int unsigned idx);
      if (idx == 3) return 32'hDEAD_BEEF;
      return 32'h5A00_0000 ^ (idx * 32'h0001_0111);
   endfunction

   function automatic bit exp_ok(input logic [AW-1:0] a);
      int unsigned word;
      word = 32'(a >> 2);
      if (word >= NR) return 1'b0;
      if (ALIGN_CHK && a[1:0] != 2'b00) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [DW+1:0] exp_beat_for(input logic [AW-1:0] a);
      if (exp_ok(a)) return {bmem(32'(a >> 2)), 2'b00};
      return {32'h0, 2'b10};
   endfunction

   // backend register file: data valid exactly one cycle after the strobe
   always @(posedge axi_clk) begin
      if (reg_read_enable) reg_read_data <= bmem(32'(reg_read_index));
      else                 reg_read_data <= 32'hBAD0_BAD0;
   end

   // one clock cycle: sample at negedge, score, return 1 time unit after posedge
   task automatic tick();
      logic [DW+1:0] exp_beat;
      logic          exp_en;
      @(negedge axi_clk);
      s_arvalid = read_addr_valid;
      s_ar_hs   = read_addr_valid && read_addr_ready;
      s_r_hs    = read_data_valid && read_data_ready;
      s_ready   = read_addr_ready;
      s_rvalid  = read_data_valid;
      s_rdata   = read_data;
      s_rresp   = read_resp;
      s_en      = reg_read_enable;
      s_idx     = reg_read_index;
      exp_en    = s_ar_hs && exp_ok(read_addr);
      n_cmp++;
      if (reg_read_enable !== exp_en) begin
         n_err++;
         $display("FAIL strobe: addr=%h reg_read_enable=%b required %b", read_addr, reg_read_enable, exp_en);
      end else if (exp_en) begin
         n_cmp++;
         if (reg_read_index !== 4'(read_addr >> 2)) begin
            n_err++;
            $display("FAIL index: addr=%h reg_read_index=%0d required %0d", read_addr, reg_read_index, 4'(read_addr >> 2));
         end
      end
      if (p_stall) begin
         n_cmp++;
         if (read_data_valid !== 1'b1 || read_data !== p_data || read_resp !== p_resp) begin
            n_err++;
            $display("FAIL r_hold: valid=%b data=%h resp=%b required valid=1 data=%h resp=%b",
                     read_data_valid, read_data, read_resp, p_data, p_resp);
         end
      end
      p_stall = read_data_valid && !read_data_ready;
      p_data  = read_data;
      p_resp  = read_resp;
      if (s_r_hs) begin
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL r_beat: unexpected beat data=%h resp=%b, required none", read_data, read_resp);
         end else begin
            exp_beat = sb_q.pop_front();
            $display("R  data=%h resp=%b", read_data, read_resp);
            if ({read_data, read_resp} !== exp_beat) begin
               n_err++;
               $display("FAIL r_beat: data=%h resp=%b required data=%h resp=%b",
                        read_data, read_resp, exp_beat[DW+1:2], exp_beat[1:0]);
            end
         end
      end
      if (s_ar_hs) begin
         sb_q.push_back(exp_beat_for(read_addr));
         $display("AR addr=%h", read_addr);
      end
      @(posedge axi_clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge axi_clk);
      #1;
      n_cmp++;
      if ({read_addr_ready, read_data_valid, read_data, read_resp, reg_read_enable, reg_read_index} !== '0) begin
         n_err++;
         $display("FAIL reset_vals: ready=%b rvalid=%b data=%h resp=%b en=%b idx=%0d required all 0",
                  read_addr_ready, read_data_valid, read_data, read_resp, reg_read_enable, reg_read_index);
      end
      @(negedge axi_clk);
      reset = 1'b0;
      @(posedge axi_clk);
      #1;
      n_cmp++;
      if (read_addr_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release: read_addr_ready=%b required 1", read_addr_ready);
      end
   endtask

   // single read of given address; checks strobe, latency and the N+2 beat
   task automatic test_single(input string name, input logic [AW-1:0] addr);
      logic [DW+1:0] exp_b;
      exp_b = exp_beat_for(addr);
      read_data_ready = 1'b1;
      read_addr = addr;
      read_addr_valid = 1'b1;
      tick();
      n_cmp++;
      if (s_ar_hs !== 1'b1 || s_en !== exp_ok(addr)) begin
         n_err++;
         $display("FAIL %s_ar: handshake=%b strobe=%b required 1 %b", name, s_ar_hs, s_en, exp_ok(addr));
      end
      read_addr_valid = 1'b0;
      tick();
      n_cmp++;
      if (s_rvalid !== 1'b0) begin
         n_err++;
         $display("FAIL %s_early: read_data_valid=%b at N+1 required 0", name, s_rvalid);
      end
      tick();
      n_cmp++;
      if (s_rvalid !== 1'b1 || {s_rdata, s_rresp} !== exp_b) begin
         n_err++;
         $display("FAIL %s_beat: valid=%b data=%h resp=%b at N+2 required 1 %h %b",
                  name, s_rvalid, s_rdata, s_rresp, exp_b[DW+1:2], exp_b[1:0]);
      end
      tick();
      n_cmp++;
      if (s_rvalid !== 1'b0) begin
         n_err++;
         $display("FAIL %s_empty: read_data_valid=%b after last pop required 0", name, s_rvalid);
      end
   endtask

   task automatic test_back_to_back();
      int idx = 0, beats = 0, first = -1, last = -1, cyc = 0, drops = 0;
      read_data_ready = 1'b1;
      read_addr = '0;
      read_addr_valid = 1'b1;
      while ((idx < 8 || beats < 8) && cyc < 50) begin
         tick();
         if (s_arvalid && !s_ready) drops++;
         if (s_r_hs) begin
            beats++;
            if (first < 0) first = cyc;
            last = cyc;
         end
         if (s_ar_hs) begin
            idx++;
            if (idx < 8) read_addr = 8'(idx * 4);
            else read_addr_valid = 1'b0;
         end
         cyc++;
      end
      n_cmp++;
      if (beats != 8 || last - first != 7) begin
         n_err++;
         $display("FAIL b2b_beats: beats=%0d span=%0d required 8 and 7", beats, last - first);
      end
      n_cmp++;
      if (drops != 0) begin
         n_err++;
         $display("FAIL b2b_arready: drops=%0d required 0", drops);
      end
   endtask

   task automatic test_full_backpressure();
      int accepts = 0, cyc = 0;
      read_data_ready = 1'b0;
      read_addr = 8'h20;
      read_addr_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (s_ar_hs) begin
            accepts++;
            read_addr = read_addr + 8'd4;
         end
      end
      n_cmp++;
      if (accepts != FD || s_ready !== 1'b0) begin
         n_err++;
         $display("FAIL full_accepts: accepted=%0d ready=%b required %0d and 0", accepts, s_ready, FD);
      end
      read_addr_valid = 1'b0;
      read_data_ready = 1'b1;
      tick();
      n_cmp++;
      if (s_r_hs !== 1'b1 || s_ready !== 1'b0) begin
         n_err++;
         $display("FAIL full_first_pop: pop=%b ready=%b required 1 and 0", s_r_hs, s_ready);
      end
      tick();
      n_cmp++;
      if (s_ready !== 1'b1) begin
         n_err++;
         $display("FAIL full_ready_return: ready=%b required 1", s_ready);
      end
      while (sb_q.size() != 0 && cyc < 20) begin
         tick();
         cyc++;
      end
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL full_drain: %0d beats outstanding required 0", sb_q.size());
      end
   endtask

   task automatic test_reset_flush();
      int accepts = 0, cyc = 0;
      read_data_ready = 1'b0;
      read_addr = 8'h10;
      read_addr_valid = 1'b1;
      while (accepts < 3 && cyc < 20) begin
         tick();
         if (s_ar_hs) begin
            accepts++;
            read_addr = read_addr + 8'd4;
            if (accepts == 3) read_addr_valid = 1'b0;
         end
         cyc++;
      end
      read_addr_valid = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (s_rvalid !== 1'b1 || accepts != 3) begin
         n_err++;
         $display("FAIL flush_fill: rvalid=%b accepted=%0d required 1 and 3", s_rvalid, accepts);
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if (read_data_valid !== 1'b0 || read_addr_ready !== 1'b0 || read_data !== '0 || read_resp !== 2'b00) begin
         n_err++;
         $display("FAIL flush_async: rvalid=%b ready=%b data=%h resp=%b required 0 0 0 0",
                  read_data_valid, read_addr_ready, read_data, read_resp);
      end
      sb_q.delete();
      p_stall = 1'b0;
      repeat (2) @(posedge axi_clk);
      @(negedge axi_clk);
      reset = 1'b0;
      @(posedge axi_clk);
      #1;
      n_cmp++;
      if (read_addr_ready !== 1'b1 || read_data_valid !== 1'b0) begin
         n_err++;
         $display("FAIL flush_release: ready=%b rvalid=%b required 1 and 0", read_addr_ready, read_data_valid);
      end
      test_single("post_reset", 8'h14);
   endtask

   initial begin
      test_reset();
      test_single("single", 8'h0C);
      test_single("out_of_range", 8'h40);
      test_single("misaligned", 8'h06);
      test_back_to_back();
      test_full_backpressure();
      test_reset_flush();
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL final_scoreboard: %0d beats outstanding required 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/axi4_lite_read_slave.md
# axi4_lite_read_slave

Parametrised AXI4-Lite read-channel slave: accepts read addresses, issues single-cycle reads to a register backend, and returns data with a proper RRESP on the R channel. Supports multiple outstanding reads via an internal response FIFO, plus range and alignment error reporting. It sits between the AXI4-Lite interconnect and the peripheral register file, alongside the existing write-side interface.

## Interface
- DATA_WIDTH, 32: R-channel and backend data width; 32 or 64.
- ADDRESS_WIDTH, 8: byte address width.
- NUM_REGS, 16: number of implemented words; word indices at or above this return SLVERR.
- FIFO_DEPTH, 4: maximum outstanding reads, power of two, at least 2.

- axi_clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- read_addr  in  ADDRESS_WIDTH  ARADDR.
- read_addr_valid  in  1  ARVALID.
- read_addr_ready  out  1  ARREADY.
- read_data  out  DATA_WIDTH  RDATA.
- read_resp  out  2  RRESP.
- read_data_valid  out  1  RVALID.
- read_data_ready  in  1  RREADY.
- reg_read_enable  out  1  backend read strobe, one cycle per accepted in-range read.
- reg_read_index  out  $clog2(NUM_REGS)  backend word index.
- reg_read_data  in  DATA_WIDTH  backend data, valid exactly one cycle after reg_read_enable.

## Operation
- Word index = read_addr >> $clog2(DATA_WIDTH/8); byte-offset bits are ignored unless alignment checking is compiled in.
- AR handshake (read_addr_valid & read_addr_ready) in cycle N:
  - In range: reg_read_enable=1 and reg_read_index driven combinationally in cycle N; reg_read_data is captured at the end of N+1 with RRESP=OKAY (2'b00).
  - Out of range: no backend strobe; data 0 with RRESP=SLVERR (2'b10) is pushed at the end of N+1 through the same pipeline slot. Response order is preserved.
- Credit counter = FIFO occupancy + in-flight (0 or 1).
- read_addr_ready = (credits < FIFO_DEPTH). It is driven from registers only and never depends on read_addr_valid or read_data_ready.
- R channel is the FIFO head: read_data_valid = !empty. read_data and read_resp stay stable while valid is high and ready is low.
- A pop on R handshake frees its credit from the next cycle on; a push and a pop in the same cycle are both honoured.
- Reset (asynchronous, any time): FIFO flushed, in-flight dropped, all outputs 0. Reads in flight are lost, which is legal because the master is reset with the slave.

## Timing
- Reset values: read_addr_ready=0 while reset is asserted, 1 in the first cycle after release. read_data_valid=0, read_data=0, read_resp=0, reg_read_enable=0, reg_read_index=0.
- Latency: AR handshake in cycle N gives read_data_valid in cycle N+2, provided the FIFO is empty.
- Throughput: one read per cycle sustained when FIFO_DEPTH≥3 and RREADY is held high. With FIFO_DEPTH=2, throughput is 2 reads per 3 cycles.
- Full: once credits reach FIFO_DEPTH, read_addr_ready drops in the next cycle. It returns in the cycle after the first R handshake.
- Empty: read_data_valid drops in the cycle after the last pop.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; the count is one bit wider.

## Configuration
- AXI4_READ_ALIGN_CHECK_EN defined: a non-zero byte offset (read_addr[$clog2(DATA_WIDTH/8)-1:0] ≠ 0) is treated like out-of-range. That means SLVERR, data 0 and no backend strobe.
- Not defined: the offset bits are ignored and a misaligned address reads the containing word with OKAY.

## Structure
- Package axi4_lite_pkg: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11, and a response typedef {data, resp}.
- Sub-module axi4_lite_resp_fifo: synchronous FIFO parametrised by width and depth, with push, pop, full, empty and count outputs. It is reusable by the write-response path.
- The top level holds the decode, in-flight register and credit logic.

## Test plan
- Single read of index 3 with backend returning 32'hDEAD_BEEF: AR at N, reg_read_enable at N, R valid at N+2 with data DEADBEEF and resp 00.
- Read of byte address 0x40 with NUM_REGS=16: no reg_read_enable, R gives data 0 and resp 10.
- Back-to-back reads of indices 0..7 with RREADY=1 and FIFO_DEPTH=4: eight consecutive R beats in order, ARREADY never drops.
- RREADY held low for 10 cycles while ARVALID stays high: exactly 4 addresses accepted, then ARREADY=0. After RREADY=1, data drains in order and ARREADY rises one cycle after the first pop.
- Address 0x06 with 32-bit data: resp 10 with AXI4_READ_ALIGN_CHECK_EN defined; index 1 data with resp 00 without it.
- Reset asserted with 3 responses queued: RVALID=0 immediately and the FIFO is empty. ARREADY=1 in the first cycle after release, and the next read returns fresh data.
